pipe_rca_adder: RTL

//   Parametrised, pipelined ripple-carry adder: WIDTH-bit a+b+cin split into STAGES chunks.
//   One chunk is added per pipeline stage; the carry is registered between stages.

---
 rtl/pipe_rca_pkg.sv | 17 +
 rtl/rca_chunk.sv | 23 ++
 rtl/pipe_rca_adder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipe_rca_pkg.sv
// Shared constants and elaboration helpers for the pipelined ripple-carry adder.
package pipe_rca_pkg;

   localparam int unsigned DEFAULT_WIDTH  = 32;
   localparam int unsigned DEFAULT_STAGES = 4;

   // Bits added per pipeline stage.
   function automatic int unsigned CHUNK_OF(input int unsigned width, input int unsigned stages);
      return (stages == 0) ? width : width / stages;
   endfunction

   // Legal geometry: at least one stage, width divides evenly into stages.
   function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
      return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from a chain of full adders.
module rca_chunk #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   logic [CHUNK:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[CHUNK];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder: one CHUNK per stage, carry registered between stages,
// global valid/ready stall. Optional signed-overflow output under PIPE_RCA_OVF_EN.
module pipe_rca_adder
   import pipe_rca_pkg::*;
#(
   parameter int unsigned WIDTH  = DEFAULT_WIDTH,
   parameter int unsigned STAGES = DEFAULT_STAGES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef PIPE_RCA_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int unsigned CHUNK = CHUNK_OF(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipe_rca_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
   end

   // Stage inputs (from ports or previous stage) and stage results.
   logic             v_in [STAGES];
   logic             c_in [STAGES];
   logic [WIDTH-1:0] a_in [STAGES];
   logic [WIDTH-1:0] b_in [STAGES];
   logic [WIDTH-1:0] s_in [STAGES];
   logic [WIDTH-1:0] s_nx [STAGES];
   logic             co   [STAGES];

   // Stage registers: operands travel with the partial sum so later chunks stay aligned.
   logic             v_q [STAGES];
   logic             c_q [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];

   logic adv;

   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK-1:0] s_chunk;

      if (k == 0) begin : g_first
         assign v_in[k] = in_valid;
         assign c_in[k] = cin;
         assign a_in[k] = a;
         assign b_in[k] = b;
         assign s_in[k] = '0;
      end else begin : g_next
         assign v_in[k] = v_q[k-1];
         assign c_in[k] = c_q[k-1];
         assign a_in[k] = a_q[k-1];
         assign b_in[k] = b_q[k-1];
         assign s_in[k] = s_q[k-1];
      end

      rca_chunk #(
         .CHUNK (CHUNK)
      ) u_chunk (
         .a  (a_in[k][k*CHUNK +: CHUNK]),
         .b  (b_in[k][k*CHUNK +: CHUNK]),
         .ci (c_in[k]),
         .s  (s_chunk),
         .co (co[k])
      );

      // Bits at and above chunk k of s_in are always zero, so OR merges the new chunk.
      assign s_nx[k] = s_in[k] | (WIDTH'(s_chunk) << (k*CHUNK));
   end

`ifdef PIPE_RCA_OVF_EN
   logic ovf_nx;

   // Carry into the MSB is a^b^s at that bit; overflow when it differs from cout.
   assign ovf_nx = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
                 ^ s_nx[STAGES-1][WIDTH-1] ^ co[STAGES-1];
`endif

   // Pipeline registers: shift together on adv, hold together on stall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            c_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
`ifdef PIPE_RCA_OVF_EN
         ovf <= 1'b0;
`endif
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= v_in[k];
            c_q[k] <= co[k];
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            s_q[k] <= s_nx[k];
         end
`ifdef PIPE_RCA_OVF_EN
         ovf <= ovf_nx;
`endif
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = c_q[STAGES-1];

endmodule
